pointer_unit: RTL



---
 rtl/cpu_pkg.sv | 13 +
 rtl/wait_state_gen.sv | 88 ++++++++
 rtl/pointer_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared widths and the wait-state FSM encoding for the datapath blocks.
package cpu_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StHold
   } wait_state_e;

endpackage

// File: rtl/wait_state_gen.sv
// Inserts WAIT_CYCLES not-ready cycles for each memory access to the slow region.
module wait_state_gen
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] SLOW_BASE   = 16'hF000,
   parameter int unsigned       WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              n_oe_mem,
   input  logic              n_we_mem,
   output logic              n_mem_rdy
);

   localparam int unsigned WaitInit = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
   localparam logic [3:0]  CntInit  = 4'(WaitInit);

   wait_state_e       state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] lat_q, lat_d;
   logic              access;
   logic              start;

   assign access = !n_oe_mem || !n_we_mem;
   assign start  = access && (addr >= SLOW_BASE) && (WAIT_CYCLES != 0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lat_d     = lat_q;
      n_mem_rdy = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StWait;
               cnt_d     = CntInit;
               lat_d     = addr;
               n_mem_rdy = 1'b1;
            end
         end
         StWait: begin
            n_mem_rdy = 1'b1;
            if (!access) begin
               state_d = StIdle;
            end else if (addr != lat_q) begin
               cnt_d = CntInit;
               lat_d = addr;
            end else if (cnt_q == 4'd0) begin
               // The stall entered in IDLE already counted as one cycle, so the
               // final count reports ready to keep the stall at exactly WAIT_CYCLES.
               state_d   = StHold;
               n_mem_rdy = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StHold: begin
            // A new address here is a fresh access; evaluate it like IDLE so
            // back-to-back slow accesses pay the full wait from their first cycle.
            if (!access || addr != lat_q) begin
               if (start) begin
                  state_d   = StWait;
                  cnt_d     = CntInit;
                  lat_d     = addr;
                  n_mem_rdy = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
      end
   end

endmodule

// File: rtl/pointer_unit.sv
// Dual pointer registers (IP/DP roles swapped by p_selector), address mux,
// ALU B drive with conflict detection, and slow-memory wait-state generation.
module pointer_unit
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000,
   parameter logic [ADDR_W-1:0] SLOW_BASE    = 16'hF000,
   parameter int unsigned       WAIT_CYCLES  = 2
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              inc_ip,
   input  logic              addr_dp,
   input  logic              p_selector,
   input  logic              n_we_pl,
   input  logic              n_we_ph,
   input  logic              n_oe_pl_alu,
   input  logic              n_oe_ph_alu,
   input  logic [DATA_W-1:0] di,
   input  logic              n_oe_mem,
   input  logic              n_we_mem,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] alu_b,
   output logic              alu_b_en,
   output logic              n_mem_rdy,
   output logic              bus_err
);

   logic [ADDR_W-1:0] p0_q, p0_d;
   logic [ADDR_W-1:0] p1_q, p1_d;
   logic [ADDR_W-1:0] ip, dp;
   logic [ADDR_W-1:0] ip_next, dp_next;
   logic              bus_err_q;
   logic              alu_conflict;

   assign ip   = p_selector ? p1_q : p0_q;
   assign dp   = p_selector ? p0_q : p1_q;
   assign addr = addr_dp ? dp : ip;

   assign alu_conflict = !n_oe_pl_alu && !n_oe_ph_alu;
   assign bus_err      = bus_err_q;

   always_comb begin
      alu_b    = '0;
      alu_b_en = 1'b0;
      if (!n_oe_pl_alu) begin
         alu_b    = dp[7:0];
         alu_b_en = 1'b1;
      end else if (!n_oe_ph_alu) begin
         alu_b    = dp[15:8];
         alu_b_en = 1'b1;
      end
   end

   always_comb begin
      ip_next = inc_ip ? ip + 16'd1 : ip;
      dp_next = dp;
      if (!n_we_pl) dp_next[7:0]  = di;
      if (!n_we_ph) dp_next[15:8] = di;

      p0_d = p0_q;
      p1_d = p1_q;
      if (!n_mem_rdy) begin
         p0_d = p_selector ? dp_next : ip_next;
         p1_d = p_selector ? ip_next : dp_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         p0_q      <= RESET_VECTOR;
         p1_q      <= '0;
         bus_err_q <= 1'b0;
      end else begin
         p0_q      <= p0_d;
         p1_q      <= p1_d;
         bus_err_q <= bus_err_q || alu_conflict;
      end
   end

   wait_state_gen #(
      .SLOW_BASE  (SLOW_BASE),
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_wait_state_gen (
      .clk      (clk),
      .n_rst    (n_rst),
      .addr     (addr),
      .n_oe_mem (n_oe_mem),
      .n_we_mem (n_we_mem),
      .n_mem_rdy(n_mem_rdy)
   );

endmodule
